// File: rtl/mul_sequencer.sv
// mul_sequencer: drives simple_calculator through an unsigned shift-and-add
// multiply of OpA by OpB[N_BITS-1:0] using two calculator registers, then
// reads the 8-bit product back over BusY.
//
// Handshake: Start is a level request sampled only in IDLE; the edge that
// sees Start=1 in IDLE accepts the operands and raises Busy. Busy stays high
// until the result is read, after which Done pulses for exactly one cycle
// with Product/Ovf valid. Start seen while Busy or in DONE is ignored (no
// queuing). Product/Ovf hold their values after Done.
module mul_sequencer #(
    parameter int         N_BITS    = 4,
    parameter logic [2:0] REG_MCAND = 3'd1,
    parameter logic [2:0] REG_ACC   = 3'd3
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Start,
    input  logic [7:0] OpA,
    input  logic [7:0] OpB,
    input  logic [7:0] BusY,
    input  logic       Carry,
    output logic       WEN,
    output logic [2:0] RW,
    output logic [2:0] RX,
    output logic [2:0] RY,
    output logic [7:0] DataIn,
    output logic       Sel,
    output logic [3:0] Ctrl,
    output logic       Busy,
    output logic       Done,
    output logic [7:0] Product,
    output logic       Ovf,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_CLR    = 3'd2,
        S_ADD    = 3'd3,
        S_SHIFT  = 3'd4,
        S_READ   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [3:0] K_LAST   = 4'(N_BITS - 1);
    localparam logic [7:0] B_MASK   = 8'((1 << N_BITS) - 1);
    localparam logic [3:0] CTRL_ADD = 4'b0000;
    localparam logic [3:0] CTRL_SLL = 4'b1010;

    state_t     state;
    logic [7:0] b_reg;      // multiplier, only the used bits kept
    logic [7:0] shadow;     // copy of REG_MCAND as it is shifted
    logic [3:0] k;          // current multiplier bit index
    logic [3:0] k_next;
    logic [7:0] rem_bits;   // multiplier bits still to be processed after a shift

    assign dbg_state = state;
    assign k_next    = k + 4'd1;
    assign rem_bits  = b_reg >> k_next;

    // Sequencer FSM; every calculator control output is registered here and
    // falls back to the idle set unless the next state drives it.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= S_IDLE;
            b_reg   <= 8'd0;
            shadow  <= 8'd0;
            k       <= 4'd0;
            WEN     <= 1'b0;
            RW      <= 3'd0;
            RX      <= 3'd0;
            RY      <= 3'd0;
            DataIn  <= 8'd0;
            Sel     <= 1'b0;
            Ctrl    <= 4'd0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Product <= 8'd0;
            Ovf     <= 1'b0;
        end else begin
            WEN    <= 1'b0;
            RW     <= 3'd0;
            RX     <= 3'd0;
            RY     <= 3'd0;
            DataIn <= 8'd0;
            Sel    <= 1'b0;
            Ctrl   <= 4'd0;
            Done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        state  <= S_LOAD_A;
                        b_reg  <= OpB & B_MASK;
                        shadow <= OpA;
                        k      <= 4'd0;
                        Ovf    <= 1'b0;
                        Busy   <= 1'b1;
                        WEN    <= 1'b1;
                        RW     <= REG_MCAND;
                        DataIn <= OpA;
                    end
                end
                S_LOAD_A: begin
                    state <= S_CLR;
                    WEN   <= 1'b1;
                    RW    <= REG_ACC;
                end
                S_CLR: begin
                    // first ADD: accumulate only if multiplier bit 0 is set
                    state <= S_ADD;
                    WEN   <= b_reg[0];
                    RW    <= REG_ACC;
                    RX    <= REG_ACC;
                    RY    <= REG_MCAND;
                    Sel   <= 1'b1;
                    Ctrl  <= CTRL_ADD;
                end
                S_ADD: begin
                    if (WEN && Carry) begin
                        Ovf <= 1'b1;
                    end
                    if (k < K_LAST) begin
                        state <= S_SHIFT;
                        WEN   <= 1'b1;
                        RW    <= REG_MCAND;
                        RX    <= REG_MCAND;
                        Sel   <= 1'b1;
                        Ctrl  <= CTRL_SLL;
                    end else begin
                        state <= S_READ;
                        RY    <= REG_ACC;
                    end
                end
                S_SHIFT: begin
                    // a bit leaving the multiplicand only matters if a later
                    // multiplier bit would still have added it in
                    if (shadow[7] && (rem_bits != 8'd0)) begin
                        Ovf <= 1'b1;
                    end
                    k      <= k_next;
                    shadow <= shadow << 1;
                    state  <= S_ADD;
                    WEN    <= b_reg[k_next[2:0]];
                    RW     <= REG_ACC;
                    RX     <= REG_ACC;
                    RY     <= REG_MCAND;
                    Sel    <= 1'b1;
                    Ctrl   <= CTRL_ADD;
                end
                S_READ: begin
                    state   <= S_DONE;
                    Product <= BusY;
                    Busy    <= 1'b0;
                    Done    <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: mul_sequencer driving a small calculator model (8x8
// register file, ADD and shift-left ALU), with results checked against an
// arithmetic reference through an expected-result queue.
module tb_mul_sequencer;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- DUT ----------------
    logic       Start;
    logic [7:0] OpA, OpB, BusY;
    logic       Carry;
    logic       WEN, Sel, Busy, Done, Ovf;
    logic [2:0] RW, RX, RY, dbg_state;
    logic [7:0] DataIn, Product;
    logic [3:0] Ctrl;

    mul_sequencer #(.N_BITS(4), .REG_MCAND(3'd1), .REG_ACC(3'd3)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .OpA(OpA), .OpB(OpB),
        .BusY(BusY), .Carry(Carry), .WEN(WEN), .RW(RW), .RX(RX), .RY(RY),
        .DataIn(DataIn), .Sel(Sel), .Ctrl(Ctrl), .Busy(Busy), .Done(Done),
        .Product(Product), .Ovf(Ovf), .dbg_state(dbg_state)
    );

    // ---------------- calculator model ----------------
    logic [7:0] cregs [8];
    logic [7:0] bus_x, alu_out;

    always_comb begin
        bus_x   = cregs[RX];
        BusY    = cregs[RY];
        alu_out = 8'd0;
        Carry   = 1'b0;
        case (Ctrl)
            4'b0000: {Carry, alu_out} = {1'b0, bus_x} + {1'b0, BusY};
            4'b1010: {Carry, alu_out} = {bus_x, 1'b0};
            default: {Carry, alu_out} = 9'd0;
        endcase
    end

    always @(posedge Clk) begin
        if (WEN) cregs[RW] <= Sel ? alu_out : DataIn;
    end

    // ---------------- bus monitor ----------------
    logic add_q [$];
    int   bad_wr = 0;

    always @(negedge Clk) begin
        if (Rst_n) begin
            if (Sel && Ctrl == 4'b0000 && RX == 3'd3 && RY == 3'd1) add_q.push_back(WEN);
            if (WEN && RW != 3'd1 && RW != 3'd3) bad_wr++;
        end
    end

    // ---------------- scoreboard ----------------
    logic [8:0] exp_q [$];
    int tests = 0;
    int fails = 0;

    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'(a) * int'(b & 8'h0F);
        return {p > 255, p[7:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic hold);
        @(negedge Clk);
        OpA   = a;
        OpB   = b;
        Start = 1'b1;
        add_q.delete();
        exp_q.push_back(model(a, b));
        @(negedge Clk);
        if (!hold) Start = 1'b0;
    endtask

    // entered at the negedge of the first cycle after the accepting edge
    task automatic wait_result(input string tag);
        int n;
        int busy_n;
        logic [8:0] e;
        n = 1;
        busy_n = Busy ? 1 : 0;
        while (!Done && n < 60) begin
            @(negedge Clk);
            n++;
            if (Busy) busy_n++;
        end
        if (!Done) begin
            check({tag, "_timeout"}, 32'(Done), 32'd1);
            exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            check({tag, "_product"}, 32'(Product), 32'(e[7:0]));
            check({tag, "_ovf"}, 32'(Ovf), 32'(e[8]));
            check({tag, "_done_cycle"}, 32'(n), 32'd11);
            check({tag, "_busy_cycles"}, 32'(busy_n), 32'd10);
        end
    endtask

    task automatic check_adds(input string tag, input logic [7:0] b);
        logic [3:0] pat;
        logic [3:0] exp_pat;
        pat = 4'd0;
        for (int i = 0; i < 4; i++) exp_pat[3-i] = b[i];
        foreach (add_q[i]) pat = {pat[2:0], add_q[i]};
        check({tag, "_add_count"}, 32'(add_q.size()), 32'd4);
        check({tag, "_add_wen"}, 32'(pat), 32'(exp_pat));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] ra, rb;
        int guard;
        Start = 1'b0;
        OpA   = 8'd0;
        OpB   = 8'd0;
        for (int i = 0; i < 8; i++) cregs[i] = 8'($urandom_range(0, 255));

        // reset state
        repeat (3) @(negedge Clk);
        check("reset_ctrl", 32'({WEN, RW, RX, RY, DataIn, Sel, Ctrl}), 32'd0);
        check("reset_status", 32'({Busy, Done, Product, Ovf}), 32'd0);
        Rst_n = 1'b1;
        @(negedge Clk);

        // 1: 3 x 5
        start_op(8'd3, 8'd5, 1'b0);
        wait_result("t1");
        check_adds("t1", 8'd5);
        repeat (3) @(negedge Clk);
        check("t1_done_pulse", 32'(Done), 32'd0);
        check("t1_product_hold", 32'(Product), 32'h0F);

        // 2: zero operands
        start_op(8'd0, 8'd15, 1'b0);
        wait_result("t2a");
        start_op(8'd200, 8'd0, 1'b0);
        wait_result("t2b");
        check_adds("t2b", 8'd0);

        // 3: carry path
        start_op(8'd255, 8'd15, 1'b0);
        wait_result("t3");

        // 4: shifted-out bit path, and its non-overflow twin
        start_op(8'h80, 8'd2, 1'b0);
        wait_result("t4a");
        start_op(8'h80, 8'd1, 1'b0);
        wait_result("t4b");

        // upper multiplier bits must be ignored
        start_op(8'd17, 8'hF3, 1'b0);
        wait_result("t_mask");

        // random operands
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            start_op(ra, rb, 1'b0);
            wait_result("t_rand");
        end

        // 5: Start held high, operands changed mid-op
        start_op(8'd9, 8'd6, 1'b1);
        OpA = 8'd50;
        OpB = 8'd13;
        wait_result("t5a");
        @(negedge Clk);
        check("t5_idle_gap", 32'(Busy), 32'd0);
        exp_q.push_back(model(8'd50, 8'd13));
        @(negedge Clk);
        check("t5_restart", 32'(Busy), 32'd1);
        Start = 1'b0;
        wait_result("t5b");

        // 6: reset during SHIFT
        start_op(8'd77, 8'd11, 1'b0);
        guard = 0;
        while (Ctrl != 4'b1010 && guard < 20) begin
            @(negedge Clk);
            guard++;
        end
        check("t6_reach_shift", 32'(Ctrl), 32'hA);
        #2 Rst_n = 1'b0;
        #1;
        check("t6_rst_ctrl", 32'({WEN, RW, RX, RY, DataIn, Sel, Ctrl}), 32'd0);
        check("t6_rst_status", 32'({Busy, Done, Product, Ovf}), 32'd0);
        exp_q.delete();
        @(negedge Clk);
        Rst_n = 1'b1;
        start_op(8'd7, 8'd3, 1'b0);
        wait_result("t6");

        check("only_mcand_acc_written", 32'(bad_wr), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
